trap_csr_seq: RTL

TRAP_CSR_SEQ -- requirements
Module: trap_csr_seq

---
 rtl/csr_pkg.sv | 17 +
 rtl/trap_vec_calc.sv | 15 +
 rtl/trap_csr_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, mstatus field positions, write modes and sequencer states shared by the trap logic.
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;
  localparam logic [1:0] WSC_NONE       = 2'b00;
  localparam logic [1:0] WSC_WRITE      = 2'b01;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;
  localparam logic [1:0] PRIV_M         = 2'b11;
  typedef enum logic [2:0] {IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, W_MRET, REDIR} state_e;
endpackage

// File: rtl/trap_vec_calc.sv
// trap_vec_calc: trap handler target from mtvec; vectored mode offsets interrupts by 4*cause.
module trap_vec_calc
  import csr_pkg::*;
(
  input  logic [31:0] mtvec_i,
  input  logic        is_int_i,
  input  logic [3:0]  code_i,
  output logic [31:0] target_o
);
  logic [31:0] base;
  always_comb begin
    base = mtvec_i & ~32'h3;
    target_o = (mtvec_i[1:0] == MTVEC_VECTORED && is_int_i) ? base + {26'b0, code_i, 2'b00} : base;
  end
endmodule

// File: rtl/trap_csr_seq.sv
// trap_csr_seq: sequences the machine-mode CSR writes for trap entry and mret, then issues a PC redirect.
module trap_csr_seq
  import csr_pkg::*;
#(
  parameter logic [11:0] MSTATUS_ADDR = CSR_MSTATUS,
  parameter logic [11:0] MTVEC_ADDR   = CSR_MTVEC,
  parameter logic [11:0] MEPC_ADDR    = CSR_MEPC,
  parameter logic [11:0] MCAUSE_ADDR  = CSR_MCAUSE,
  parameter logic [11:0] MTVAL_ADDR   = CSR_MTVAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_valid,
  input  logic        trap_is_int,
  input  logic [3:0]  trap_code,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        csr_w,
  output logic [1:0]  csr_wsc_mode,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  state_e      state_q, state_d;
  logic        is_int_q, is_int_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d, tval_q, tval_d;
  logic        csr_w_q, csr_w_d, rv_q, rv_d, accept, wr_st;
  logic [11:0] waddr_q, waddr_d, addr_sel;
  logic [31:0] wdata_q, wdata_d, data_sel, rpc_q, rpc_d, vec_pc, mst_trap, mst_mret;
  logic [1:0]  mode_q, mode_d;
  trap_vec_calc u_vec (.mtvec_i(mtvec_in), .is_int_i(is_int_q), .code_i(code_q), .target_o(vec_pc));
  always_comb begin
    accept = state_q == IDLE && trap_valid && (!trap_is_int || mstatus_in[MIE_BIT]);
    stall = state_q != IDLE || accept || mret_valid;
    is_int_d = accept ? trap_is_int : is_int_q;
    code_d = accept ? trap_code : code_q;
    pc_d = accept ? trap_pc & ~32'h3 : pc_q;
    tval_d = accept ? trap_tval : tval_q;
    mst_trap = mstatus_in;
    mst_trap[MPIE_BIT] = mstatus_in[MIE_BIT];
    mst_trap[MIE_BIT] = 1'b0;
    mst_trap[MPP_HI:MPP_LO] = PRIV_M;
    mst_mret = mstatus_in;
    mst_mret[MIE_BIT] = mstatus_in[MPIE_BIT];
    mst_mret[MPIE_BIT] = 1'b1;
    case (state_q)
      IDLE:     state_d = accept ? W_MEPC : mret_valid ? W_MRET : IDLE;
      W_MEPC:   state_d = W_MCAUSE;
      W_MCAUSE: state_d = W_MTVAL;
      W_MTVAL:  state_d = W_MSTAT;
      W_MSTAT:  state_d = REDIR;
      W_MRET:   state_d = REDIR;
      default:  state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they register in the same edge as the transition.
    addr_sel = state_d == W_MEPC ? MEPC_ADDR : state_d == W_MCAUSE ? MCAUSE_ADDR :
               state_d == W_MTVAL ? MTVAL_ADDR : MSTATUS_ADDR;
    data_sel = state_d == W_MEPC ? pc_d : state_d == W_MCAUSE ? {is_int_d, 27'b0, code_d} :
               state_d == W_MTVAL ? tval_d : state_d == W_MSTAT ? mst_trap : mst_mret;
    wr_st = state_d != IDLE && state_d != REDIR;
    // mtvec is owned by the CSR file; a misconfigured address map must never let us overwrite it.
    csr_w_d = wr_st && addr_sel != MTVEC_ADDR;
    waddr_d = csr_w_d ? addr_sel : 12'h0;
    wdata_d = csr_w_d ? data_sel : 32'h0;
    mode_d = csr_w_d ? WSC_WRITE : WSC_NONE;
    rv_d = state_d == REDIR;
    rpc_d = !rv_d ? 32'h0 : state_q == W_MRET ? mepc_in : vec_pc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      is_int_q <= 1'b0;
      code_q <= 4'h0;
      pc_q <= 32'h0;
      tval_q <= 32'h0;
      csr_w_q <= 1'b0;
      waddr_q <= 12'h0;
      wdata_q <= 32'h0;
      mode_q <= WSC_NONE;
      rv_q <= 1'b0;
      rpc_q <= 32'h0;
    end else begin
      state_q <= state_d;
      is_int_q <= is_int_d;
      code_q <= code_d;
      pc_q <= pc_d;
      tval_q <= tval_d;
      csr_w_q <= csr_w_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      mode_q <= mode_d;
      rv_q <= rv_d;
      rpc_q <= rpc_d;
    end
  end
  assign csr_w = csr_w_q;
  assign csr_waddr = waddr_q;
  assign csr_wdata = wdata_q;
  assign csr_wsc_mode = mode_q;
  assign redirect_valid = rv_q;
  assign redirect_pc = rpc_q;
endmodule
